// File: rtl/denise_joy_regs.sv
// Denise mouse/joystick counter registers: accumulates quadrature decoder counts
// into JOY0DAT/JOY1DAT, handles JOYTEST preload and registered RGA reads.
module denise_joy_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  m0h_cnt,
  input  logic [7:0]  m0v_cnt,
  input  logic [7:0]  m1h_cnt,
  input  logic [7:0]  m1v_cnt,
  input  logic [7:0]  rga,
  input  logic        rga_strobe,
  input  logic        rga_write,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [15:0] joy0dat,
  output logic [15:0] joy1dat
);

  localparam logic [7:0] ADDR_JOY0DAT = 8'h05;
  localparam logic [7:0] ADDR_JOY1DAT = 8'h06;
  localparam logic [7:0] ADDR_JOYTEST = 8'h1B;

  // Lane order: 0 = H0, 1 = V0, 2 = H1, 3 = V1 (odd lanes are vertical)
  logic [7:0] cnt      [4];
  logic [7:0] acc      [4];
  logic [7:0] prev     [4];
  logic [7:0] base     [4];
  logic [7:0] acc_next [4];
  logic       init;
  logic       joytest_wr;
  logic       rd_hit;

  always_comb begin
    cnt[0] = m0h_cnt;
    cnt[1] = m0v_cnt;
    cnt[2] = m1h_cnt;
    cnt[3] = m1v_cnt;
  end

  assign joytest_wr = rga_strobe & rga_write & (rga == ADDR_JOYTEST);
  assign rd_hit     = rga_strobe & ~rga_write &
                      ((rga == ADDR_JOY0DAT) | (rga == ADDR_JOY1DAT));

  // Modular 8-bit add of (cnt - prev) equals adding the signed delta mod 256
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      base[i] = acc[i];
      if (joytest_wr)
        base[i] = {(i[0] ? wr_data[15:10] : wr_data[7:2]), acc[i][1:0]};
      acc_next[i] = init ? acc[i] : base[i] + (cnt[i] - prev[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        acc[i]  <= '0;
        prev[i] <= '0;
      end
      init     <= 1'b1;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        acc[i]  <= acc_next[i];
        prev[i] <= cnt[i];
      end
      init     <= 1'b0;
      rd_valid <= rd_hit;
      if (rd_hit)
        rd_data <= (rga == ADDR_JOY0DAT) ? joy0dat : joy1dat;
    end
  end

  assign joy0dat = {acc[1], acc[0]};
  assign joy1dat = {acc[3], acc[2]};

endmodule

// File: tb/tb_denise_joy_regs.sv
// Self-checking bench for denise_joy_regs: directed cases plus randomized traffic
// checked against a signed-delta integer model of the counters.
module tb_denise_joy_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cnt [4];
  logic [7:0]  rga;
  logic        rga_strobe;
  logic        rga_write;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [15:0] joy0dat;
  logic [15:0] joy1dat;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          macc  [4];
  int          mprev [4];
  bit          minit;
  logic [15:0] mrd;
  bit          mvalid;

  always #5 clk = ~clk;

  denise_joy_regs dut (
    .clk        (clk),
    .reset      (reset),
    .m0h_cnt    (cnt[0]),
    .m0v_cnt    (cnt[1]),
    .m1h_cnt    (cnt[2]),
    .m1v_cnt    (cnt[3]),
    .rga        (rga),
    .rga_strobe (rga_strobe),
    .rga_write  (rga_write),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .joy0dat    (joy0dat),
    .joy1dat    (joy1dat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mjoy(input int hi, input int lo);
    logic [7:0] h = hi[7:0];
    logic [7:0] l = lo[7:0];
    return {h, l};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      macc[i]  = 0;
      mprev[i] = 0;
    end
    minit  = 1;
    mrd    = '0;
    mvalid = 0;
  endtask

  // One clock of behaviour from the register-level rules
  task automatic model_edge();
    int d;
    int b;
    int w;
    if (rga_strobe && !rga_write && (rga == 8'h05 || rga == 8'h06)) begin
      mvalid = 1;
      mrd = (rga == 8'h05) ? mjoy(macc[1], macc[0]) : mjoy(macc[3], macc[2]);
    end else begin
      mvalid = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (!minit) begin
        d = int'(cnt[i]) - mprev[i];
        if (d > 127) d -= 256;
        if (d < -128) d += 256;
        b = macc[i];
        if (rga_strobe && rga_write && rga == 8'h1B) begin
          w = (i % 2 == 1) ? int'(wr_data[15:10]) : int'(wr_data[7:2]);
          b = w * 4 + (macc[i] % 4);
        end
        macc[i] = (b + d + 256) % 256;
      end
      mprev[i] = int'(cnt[i]);
    end
    minit = 0;
  endtask

  task automatic compare_all();
    check("joy0dat",  joy0dat,  mjoy(macc[1], macc[0]));
    check("joy1dat",  joy1dat,  mjoy(macc[3], macc[2]));
    check("rd_valid", rd_valid, mvalid);
    check("rd_data",  rd_data,  mrd);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic bus(input logic s, input logic w, input logic [7:0] a, input logic [15:0] d);
    rga_strobe = s;
    rga_write  = w;
    rga        = a;
    wr_data    = d;
  endtask

  // Assert reset between edges, check async clear, then release
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 8'h00;
    cnt[0] = 8'h37;
    bus(1'b0, 1'b0, 8'h00, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data", rd_data, 16'h0000);
    check("reset_joy0", joy0dat, 16'h0000);
    compare_all();
    reset = 1'b0;
    tick();
    check("capture_joy0", joy0dat, 16'h0000);
    tick();
    check("post_capture_joy0", joy0dat, 16'h0000);

    // Wrap upward then downward through zero
    cnt[0] = 8'hFE;
    pulse_reset();
    tick();
    cnt[0] = 8'hFF; tick();
    cnt[0] = 8'h00; tick();
    cnt[0] = 8'h01; tick();
    check("h0_wrap_up", joy0dat[7:0], 8'h03);
    cnt[0] = 8'hFC; tick();
    check("h0_wrap_down", joy0dat[7:0], 8'hFE);

    // JOYTEST preload
    for (int i = 0; i < 4; i++) cnt[i] = 8'h00;
    pulse_reset();
    tick();
    for (int i = 0; i < 4; i++) cnt[i] = 8'h02;
    tick();
    check("acc_at_2", joy1dat, 16'h0202);
    bus(1'b1, 1'b1, 8'h1B, 16'hA5F3);
    tick();
    check("joytest_joy0", joy0dat, 16'hA6F2);
    check("joytest_joy1", joy1dat, 16'hA6F2);
    cnt[3] = 8'h03;
    tick();
    check("joytest_delta_v1", joy1dat[15:8], 8'hA7);
    check("joytest_delta_joy0", joy0dat, 16'hA6F2);

    // Read with concurrent increment returns pre-update snapshot
    bus(1'b1, 1'b0, 8'h05, 16'h0000);
    cnt[1] = 8'h03;
    tick();
    bus(1'b0, 1'b0, 8'h00, 16'h0000);
    check("read_pre_inc", rd_data, 16'hA6F2);
    check("read_valid", rd_valid, 1'b1);
    tick();
    check("read_valid_pulse", rd_valid, 1'b0);
    bus(1'b1, 1'b0, 8'h05, 16'h0000);
    tick();
    check("read_post_inc", rd_data, 16'hA7F2);

    // Non-readable addresses and ignored writes
    bus(1'b1, 1'b0, 8'h1B, 16'h0000);
    tick();
    check("read_1b_valid", rd_valid, 1'b0);
    check("read_1b_data", rd_data, 16'hA7F2);
    bus(1'b1, 1'b0, 8'h10, 16'h0000);
    tick();
    check("read_10_valid", rd_valid, 1'b0);
    check("read_10_data", rd_data, 16'hA7F2);
    bus(1'b1, 1'b1, 8'h05, 16'h1234);
    tick();
    check("write_05_ignored", joy0dat, 16'hA7F2);

    // Reset right after a read strobe
    bus(1'b1, 1'b0, 8'h06, 16'h0000);
    tick();
    bus(1'b0, 1'b0, 8'h00, 16'h0000);
    check("read_06_valid", rd_valid, 1'b1);
    pulse_reset();
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_joy1", joy1dat, 16'h0000);
    cnt[0] = cnt[0] + 8'd5;
    tick();
    check("recapture_joy0", joy0dat, 16'h0000);
    tick();
    check("recapture_hold", joy0dat, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 254);
        cnt[i] = cnt[i] + 8'(r - 127);
      end
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: bus(1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? 8'h05 : 8'h06, 16'h0000);
        3:       bus(1'b1, 1'b1, 8'h1B, 16'($urandom));
        4:       bus(1'b1, $urandom_range(0, 1) != 0, 8'($urandom), 16'($urandom));
        5:       bus(1'b1, 1'b0, 8'h1B, 16'h0000);
        default: bus(1'b0, 1'($urandom_range(0, 1)), 8'h1B, 16'($urandom));
      endcase
      tick();
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/denise_joy_regs.md
# denise_joy_regs

Mouse/joystick counter register stage of the Denise replacement. It consumes the four free-running 8-bit counts produced by the quadrature decoders (M0H, M0V, M1H, M1V) and accumulates them into the software-visible JOY0DAT and JOY1DAT counters. It applies JOYTEST preload writes and serves register reads on the RGA bus with a one-cycle registered response. It sits between the four quadrature decoders and the Denise read-data mux.

## Interface
- No parameters. Register addresses are fixed as RGA[8:1] values: JOY0DAT = 8'h05, JOY1DAT = 8'h06, JOYTEST = 8'h1B.
- clk  in  1  single system clock (CCKQ domain), all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- m0h_cnt  in  8  decoder count, mouse 0 horizontal.
- m0v_cnt  in  8  decoder count, mouse 0 vertical.
- m1h_cnt  in  8  decoder count, mouse 1 horizontal.
- m1v_cnt  in  8  decoder count, mouse 1 vertical.
- rga  in  8  register address RGA[8:1].
- rga_strobe  in  1  one-cycle access strobe.
- rga_write  in  1  1 = write, 0 = read; qualified by rga_strobe.
- wr_data  in  16  write data.
- rd_data  out  16  registered read data.
- rd_valid  out  1  one-cycle pulse when rd_data holds a valid read.
- joy0dat  out  16  live JOY0DAT {V0[7:0], H0[7:0]}.
- joy1dat  out  16  live JOY1DAT {V1[7:0], H1[7:0]}.

## Operation
- Four independent 8-bit accumulators: H0, V0, H1, V1. Each accumulator has a prev register holding the decoder count from the previous clk.
- Each clk: delta = (cnt - prev) mod 256, interpreted as signed -128..+127. The accumulator adds delta mod 256, and prev <= cnt. Wrap is modular: 8'hFF + 1 = 8'h00, and 8'h00 - 1 = 8'hFF.
- Init: the first clk after reset deasserts is a capture cycle. prev <= cnt and the accumulators do not change. An init flag, set by reset and cleared after that cycle, controls this.
- JOYTEST write (rga_strobe & rga_write & rga == 8'h1B): all four accumulators load {wr_data[15:10], acc[1:0]} for V and {wr_data[7:2], acc[1:0]} for H. The same value goes to both ports. That cycle's delta is added on top: acc <= {w[7:2], acc[1:0]} + delta.
- Writes to JOY0DAT, JOY1DAT or any other address are ignored.
- Read (rga_strobe & !rga_write): address 8'h05 returns joy0dat and 8'h06 returns joy1dat, sampled from the accumulator values before the current cycle's update. Both bytes come from the same clk, so the snapshot is coherent. rd_valid pulses. Any other address, including JOYTEST, gives no rd_valid and rd_data holds its previous value.
- A read and a JOYTEST write cannot coincide, since there is one strobe per cycle.

## Timing
- Reset values: all accumulators 0, prev 0, init flag 1, rd_data 16'h0000, rd_valid 0, joy0dat and joy1dat 16'h0000.
- Count to joy output: 1 clk. A decoder count change at edge N appears on joy0dat/joy1dat after edge N+1.
- Read latency: strobe sampled at edge N gives rd_data/rd_valid valid after edge N, for one clk.
- JOYTEST: the loaded value is visible on joy outputs after the sampling edge.
- Reset asserted mid-operation clears everything asynchronously, including a pending rd_valid. The next post-reset cycle is a capture cycle again.
- Decoder counts must change by at most ±127 between clk edges. Larger jumps alias, and this is accepted by design.

## Test plan
- Reset release with m0h_cnt = 8'h37 held -> joy0dat stays 16'h0000 through the capture cycle and afterwards.
- m0h_cnt stepped 8'hFE → 8'hFF → 8'h00 → 8'h01 over 3 clks from a zero accumulator -> H0 = 8'h03. Then stepped down 5 -> H0 = 8'hFE, wrapping correctly.
- JOYTEST write 16'hA5F3 with all accumulators at 8'h02 -> joy0dat = joy1dat = 16'hA6F2. Repeat with a concurrent m1v +1 step -> V1 = 8'hA7.
- Read 8'h05 while m0v_cnt increments in the same cycle -> rd_data shows the pre-increment V0, rd_valid high for exactly 1 clk. The next read shows the incremented value.
- Read 8'h1B and read 8'h10 -> rd_valid stays 0 and rd_data is unchanged. Write to 8'h05 -> joy0dat is unchanged.
- Assert reset in the cycle after a read strobe -> rd_valid and rd_data drop to 0 immediately. Accumulators return to 0, and a capture cycle occurs after release.
